// File: rtl/alu_mul_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier with valid/ready handshakes on both sides.
// The optional early-termination path is enabled with the ALU_MUL_EARLY_TERM_EN macro.
// The team's 8-bit ripple adder (adder_8bit) is kept in this file so the block is
// self-contained.

module adder_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    input  logic       Add_mode,
    output logic [7:0] Sum,
    output logic       Cout,
    output logic       v_flag
);

    // Ripple carry chain; Add_mode=1 turns the adder into A - B (two's complement).
    always_comb begin
        logic [7:0] b_eff;
        logic       carry;
        logic       carry_into_msb;
        b_eff          = B ^ {8{Add_mode}};
        carry          = Cin ^ Add_mode;
        carry_into_msb = 1'b0;
        Sum            = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) carry_into_msb = carry;
            Sum[i] = A[i] ^ b_eff[i] ^ carry;
            carry  = (A[i] & b_eff[i]) | (A[i] & carry) | (b_eff[i] & carry);
        end
        Cout   = carry;
        v_flag = carry ^ carry_into_msb;
    end

endmodule

module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 v_flag,
    output logic                 busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t     state_q;
    logic [7:0] m_q;
    logic [7:0] acc_q;
    logic [7:0] mq_q;
    logic [3:0] cnt_q;
`ifdef ALU_MUL_EARLY_TERM_EN
    logic [7:0] mr_q;
    logic [15:0] early_prod;
`endif

    logic [7:0] add_sum;
    logic       add_cout;
    logic [7:0] acc_nxt;
    logic [7:0] mq_nxt;

    adder_8bit u_adder (
        .A        (acc_q),
        .B        (m_q),
        .Cin      (1'b0),
        .Add_mode (1'b0),
        .Sum      (add_sum),
        .Cout     (add_cout),
        .v_flag   ()
    );

    // One shift-and-add step; the carry-out lands in acc[7] so nothing is lost.
    always_comb begin
        if (mq_q[0]) begin
            {acc_nxt, mq_nxt} = {add_cout, add_sum, mq_q[7:1]};
        end else begin
            {acc_nxt, mq_nxt} = {1'b0, acc_q, mq_q[7:1]};
        end
    end

`ifdef ALU_MUL_EARLY_TERM_EN
    // Remaining multiplier bits are zero: realign the partial product as if fully shifted.
    always_comb begin
        early_prod = {acc_q, mq_q} >> (4'd8 - cnt_q);
    end
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            Product   <= '0;
            v_flag    <= 1'b0;
            m_q       <= 8'h00;
            acc_q     <= 8'h00;
            mq_q      <= 8'h00;
            cnt_q     <= 4'd0;
`ifdef ALU_MUL_EARLY_TERM_EN
            mr_q      <= 8'h00;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        m_q      <= A;
                        mq_q     <= B;
                        acc_q    <= 8'h00;
                        cnt_q    <= 4'd0;
`ifdef ALU_MUL_EARLY_TERM_EN
                        mr_q     <= B;
`endif
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
`ifdef ALU_MUL_EARLY_TERM_EN
                    if (mr_q == 8'h00) begin
                        Product   <= early_prod;
                        v_flag    <= |early_prod[15:8];
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        mr_q <= mr_q >> 1;
`endif
                        acc_q <= acc_nxt;
                        mq_q  <= mq_nxt;
                        cnt_q <= cnt_q + 4'd1;
                        // Eighth step: capture the post-shift partial product.
                        if (cnt_q == 4'd7) begin
                            Product   <= {acc_nxt, mq_nxt};
                            v_flag    <= |acc_nxt;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            state_q   <= StDone;
                        end
`ifdef ALU_MUL_EARLY_TERM_EN
                    end
`endif
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed cases, back-pressure, mid-operation reset,
// and randomized operands checked against plain integer multiplication.

module tb_alu_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Product;
    logic        v_flag;
    logic        busy;

    int err_cnt = 0;
    int chk_cnt = 0;

    alu_mul_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Product   (Product),
        .v_flag    (v_flag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected number of CALC cycles from the operand B alone.
    function automatic int exp_latency(input logic [7:0] b);
`ifdef ALU_MUL_EARLY_TERM_EN
        int msb;
        if (b == 8'h00) return 1;
        msb = 0;
        for (int i = 0; i < 8; i++) if (b[i]) msb = i;
        return (msb + 2 > 8) ? 8 : msb + 2;
`else
        return (b == b) ? 8 : 8;
`endif
    endfunction

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int bp);
        logic [15:0] exp_p;
        int          n;
        exp_p = 16'(a) * 16'(b);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A        = 8'($urandom);
        B        = 8'($urandom);
        check("busy_calc", 32'(busy), 32'd1);
        check("in_ready_calc", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (!out_valid && n < exp_latency(b)) begin
                // in_valid toggling during CALC must be ignored
                in_valid = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("latency", 32'(n), 32'(exp_latency(b)));
        check("product", 32'(Product), 32'(exp_p));
        check("v_flag", 32'(v_flag), 32'(exp_p[15:8] != 8'h00));
        check("busy_done", 32'(busy), 32'd0);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            A        = 8'($urandom);
            B        = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_product", 32'(Product), 32'(exp_p));
            check("bp_v_flag", 32'(v_flag), 32'(exp_p[15:8] != 8'h00));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 8'h00;
        B         = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", 32'(Product), 32'd0);
        check("rst_v_flag", 32'(v_flag), 32'd0);

        do_op(8'd200, 8'd100, 0);
        do_op(8'hFF, 8'hFF, 0);
        do_op(8'h0F, 8'h0F, 1);
        do_op(8'h5A, 8'h00, 0);
        do_op(8'h00, 8'hC3, 0);
        do_op(8'hFF, 8'h01, 0);
        do_op(8'hA7, 8'h80, 2);
        do_op(8'd200, 8'd100, 5);

        // Reset during the fourth CALC cycle of 200*100.
        @(negedge clk);
        in_valid = 1'b1;
        A        = 8'd200;
        B        = 8'd100;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_product", 32'(Product), 32'd0);
        check("midrst_v_flag", 32'(v_flag), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_result", 32'(seen), 32'd0);
        do_op(8'd3, 8'd7, 0);

        for (int k = 0; k < 40; k++) begin
            do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
